// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_MUL, S_LOOKUP, S_NR_A, S_NR_B, S_Q_A, S_Q_B, S_Q_SEL, S_RESULT
  } state_e;

  // {oe1[1:0], oe2} per state
  localparam logic [2:0] OE_IDLE   = 3'b000;
  localparam logic [2:0] OE_MUL    = 3'b000;
  localparam logic [2:0] OE_LOOKUP = 3'b110;
  localparam logic [2:0] OE_NR_A   = 3'b110;
  localparam logic [2:0] OE_NR_B   = 3'b101;
  localparam logic [2:0] OE_Q_A    = 3'b011;
  localparam logic [2:0] OE_Q_B    = 3'b010;
  localparam logic [2:0] OE_Q_SEL  = 3'b000;

  localparam int unsigned PASSES_MUL    = 1;
  localparam int unsigned PASSES_DIV_SP = 8;
  localparam int unsigned PASSES_DIV_DP = 10;

  localparam logic [1:0] ITER_SP = 2'd2;
  localparam logic [1:0] ITER_DP = 2'd3;

  function automatic logic [2:0] oe_enc(input state_e s);
    case (s)
      S_MUL:    return OE_MUL;
      S_LOOKUP: return OE_LOOKUP;
      S_NR_A:   return OE_NR_A;
      S_NR_B:   return OE_NR_B;
      S_Q_A:    return OE_Q_A;
      S_Q_B:    return OE_Q_B;
      S_Q_SEL:  return OE_Q_SEL;
      default:  return OE_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] last_pass_idx(input logic fdiv, input logic db);
    int unsigned n;
    n = !fdiv ? PASSES_MUL : (db ? PASSES_DIV_DP : PASSES_DIV_SP);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/md_pass_timer.sv
// Loadable down-counter; pass_last_o marks the final cycle of a LAT-cycle pass.
module md_pass_timer #(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic pass_last_o
);

  localparam logic [1:0] RELOAD = 2'(LAT - 1);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = RELOAD;
    else if (cnt_q != 2'd0)  cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pass_last_o = (cnt_q == 2'd0);

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide pass sequencer for an FP significand datapath.
// Optional MD_SEQ_PERF_EN adds perf_div_cnt, a count of consumed divide results.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        op_fdiv,
  input  logic        op_db,
  input  logic [56:0] fq_dp,
  output logic        dp_fdiv,
  output logic        dp_db,
  output logic [1:0]  oe1,
  output logic        oe2,
  output logic [3:0]  pass_idx,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [56:0] res_fq
`ifdef MD_SEQ_PERF_EN
  ,
  output logic [15:0] perf_div_cnt
`endif
);

  state_e      state_q, state_d;
  logic        dp_fdiv_q, dp_db_q;
  logic [2:0]  oe_q, oe_d;
  logic [3:0]  pass_idx_q, pass_idx_d;
  logic [1:0]  iter_q, iter_d;
  logic        res_valid_q;
  logic [56:0] res_fq_q;
  logic        pass_last, timer_load, accept, capture, in_pass;

  md_pass_timer #(.LAT(MUL_LAT)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (timer_load),
    .pass_last_o (pass_last)
  );

  assign start_ready = (state_q == S_IDLE) || (state_q == S_RESULT && res_ready);
  assign accept      = start_valid && start_ready;
  assign in_pass     = (state_q != S_IDLE) && (state_q != S_RESULT);
  assign capture     = in_pass && pass_last &&
                       (pass_idx_q == last_pass_idx(dp_fdiv_q, dp_db_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = op_fdiv ? S_LOOKUP : S_MUL;
      S_MUL:    if (pass_last) state_d = S_RESULT;
      S_LOOKUP: if (pass_last) state_d = S_NR_A;
      S_NR_A:   if (pass_last) state_d = S_NR_B;
      S_NR_B:   if (pass_last) state_d = (iter_q == 2'd1) ? S_Q_A : S_NR_A;
      S_Q_A:    if (pass_last) state_d = S_Q_B;
      S_Q_B:    if (pass_last) state_d = S_Q_SEL;
      S_Q_SEL:  if (pass_last) state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = accept ? (op_fdiv ? S_LOOKUP : S_MUL) : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    iter_d = iter_q;
    if (accept)                              iter_d = op_db ? ITER_DP : ITER_SP;
    else if (state_q == S_NR_B && pass_last) iter_d = iter_q - 2'd1;

    // Every non-terminal state change is a pass boundary, so it advances pass_idx.
    pass_idx_d = pass_idx_q;
    if (accept || state_d == S_IDLE)                   pass_idx_d = '0;
    else if (state_d != state_q && state_d != S_RESULT) pass_idx_d = pass_idx_q + 4'd1;

    timer_load = (state_d != state_q);
    oe_d       = (state_d == S_RESULT) ? oe_q : oe_enc(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dp_fdiv_q   <= 1'b0;
      dp_db_q     <= 1'b0;
      oe_q        <= '0;
      pass_idx_q  <= '0;
      iter_q      <= '0;
      res_valid_q <= 1'b0;
      res_fq_q    <= '0;
    end else begin
      state_q     <= state_d;
      oe_q        <= oe_d;
      pass_idx_q  <= pass_idx_d;
      iter_q      <= iter_d;
      res_valid_q <= (state_d == S_RESULT);
      if (accept) begin
        dp_fdiv_q <= op_fdiv;
        dp_db_q   <= op_db;
      end
      if (capture) res_fq_q <= fq_dp;
    end
  end

`ifdef MD_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      perf_q <= '0;
    else if (res_valid_q && res_ready && dp_fdiv_q)  perf_q <= perf_q + 16'd1;
  end

  assign perf_div_cnt = perf_q;
`endif

  assign dp_fdiv   = dp_fdiv_q;
  assign dp_db     = dp_db_q;
  assign oe1       = oe_q[2:1];
  assign oe2       = oe_q[0];
  assign pass_idx  = pass_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_fq    = res_fq_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: MUL_LAT=2 and MUL_LAT=1 instances share stimulus.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        sv, rr, op_fdiv, op_db;
  logic [56:0] fq_dp;

  logic        sr0, sr1, df0, df1, db0, db1, oe2_0, oe2_1, bz0, bz1, rv0, rv1;
  logic [1:0]  oe1_0, oe1_1;
  logic [3:0]  pi0, pi1;
  logic [56:0] rf0, rf1;
`ifdef MD_SEQ_PERF_EN
  logic [15:0] pc0, pc1;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MUL_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv & ~sel), .start_ready(sr0),
    .op_fdiv(op_fdiv), .op_db(op_db), .fq_dp(fq_dp), .dp_fdiv(df0), .dp_db(db0),
    .oe1(oe1_0), .oe2(oe2_0), .pass_idx(pi0), .busy(bz0), .res_valid(rv0),
    .res_ready(rr), .res_fq(rf0)
`ifdef MD_SEQ_PERF_EN
    , .perf_div_cnt(pc0)
`endif
  );

  md_sequencer #(.MUL_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv & sel), .start_ready(sr1),
    .op_fdiv(op_fdiv), .op_db(op_db), .fq_dp(fq_dp), .dp_fdiv(df1), .dp_db(db1),
    .oe1(oe1_1), .oe2(oe2_1), .pass_idx(pi1), .busy(bz1), .res_valid(rv1),
    .res_ready(rr), .res_fq(rf1)
`ifdef MD_SEQ_PERF_EN
    , .perf_div_cnt(pc1)
`endif
  );

  wire        o_sr = sel ? sr1 : sr0;
  wire        o_df = sel ? df1 : df0;
  wire        o_db = sel ? db1 : db0;
  wire [2:0]  o_oe = sel ? {oe1_1, oe2_1} : {oe1_0, oe2_0};
  wire [3:0]  o_pi = sel ? pi1 : pi0;
  wire        o_bz = sel ? bz1 : bz0;
  wire        o_rv = sel ? rv1 : rv0;
  wire [56:0] o_rf = sel ? rf1 : rf0;

  typedef struct {
    logic        sel;
    logic        fdiv;
    logic        db;
    logic [56:0] fq;
    int unsigned lat;
    int unsigned npass;
    logic [29:0] oeseq;  // expected {oe1,oe2} of pass p at [3p +: 3]
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned last;
    int unsigned p;
    last = v.npass * v.lat;
    @(negedge clk);
    sel = v.sel; rr = 1'b0; sv = 1'b1;
    op_fdiv = v.fdiv; op_db = v.db; fq_dp = ~v.fq;
    #1 chk("start_ready_idle", 64'(o_sr), 64'd1);
    for (int unsigned c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      op_fdiv = ~v.fdiv; op_db = ~v.db;
      fq_dp   = (c == last) ? v.fq : ~v.fq;
      if (c <= last) begin
        p = (c - 1) / v.lat;
        chk("oe_seq",        64'(o_oe), 64'(v.oeseq[3*p +: 3]));
        chk("pass_idx",      64'(o_pi), 64'(p));
        chk("res_valid_lo",  64'(o_rv), 64'd0);
        chk("busy",          64'(o_bz), 64'd1);
        chk("start_rdy_bsy", 64'(o_sr), 64'd0);
        chk("dp_fdiv",       64'(o_df), 64'(v.fdiv));
        chk("dp_db",         64'(o_db), 64'(v.db));
      end else begin
        chk("res_valid_hi",  64'(o_rv), 64'd1);
        chk("res_fq",        64'(o_rf), 64'(v.fq));
        chk("oe_result",     64'(o_oe), 64'd0);
        sv = 1'b0; rr = 1'b1;
      end
    end
    @(negedge clk);
    chk("rv_after_cons",   64'(o_rv), 64'd0);
    chk("idle_busy",       64'(o_bz), 64'd0);
    chk("idle_pass_idx",   64'(o_pi), 64'd0);
    chk("idle_start_rdy",  64'(o_sr), 64'd1);
    rr = 1'b0;
  endtask

  task automatic wait_consume(input int unsigned budget);
    int unsigned i;
    i = 0;
    while (!o_rv && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("result_timeout", 64'(o_rv), 64'd1);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
  endtask

  initial begin
    logic [56:0] x;
    logic        seen;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 57'h1, 2, 1, 30'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 57'h123_4567_89AB_CDEF, 2, 8,
                {3'b000, 3'b000, 3'b000, 3'b010, 3'b011, 3'b101, 3'b110, 3'b101, 3'b110, 3'b110}};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 57'h0AA_5555_AAAA_5555, 1, 10,
                {3'b000, 3'b010, 3'b011, 3'b101, 3'b110, 3'b101, 3'b110, 3'b101, 3'b110, 3'b110}};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 57'h1FF_FFFF_FFFF_FFFE, 2, 10,
                {3'b000, 3'b010, 3'b011, 3'b101, 3'b110, 3'b101, 3'b110, 3'b101, 3'b110, 3'b110}};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 57'h0DE_ADBE_EF01_2345, 1, 1, 30'd0};

    rst_n = 1'b0; sel = 1'b0; sv = 1'b0; rr = 1'b0;
    op_fdiv = 1'b0; op_db = 1'b0; fq_dp = '0;
    repeat (2) @(negedge clk);
    chk("rst_oe",       64'(o_oe), 64'd0);
    chk("rst_pass_idx", 64'(o_pi), 64'd0);
    chk("rst_busy",     64'(o_bz), 64'd0);
    chk("rst_res_valid",64'(o_rv), 64'd0);
    chk("rst_res_fq",   64'(o_rf), 64'd0);
    chk("rst_dp",       64'({o_df, o_db}), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Result back-pressure, then consume and accept in the same cycle.
    x = 57'h0AB_CDEF_0123_4567;
    @(negedge clk);
    sel = 1'b0; sv = 1'b1; op_fdiv = 1'b0; op_db = 1'b0; fq_dp = x; rr = 1'b0;
    @(negedge clk); sv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_res_valid", 64'(o_rv), 64'd1);
    for (int i = 0; i < 5; i++) begin
      fq_dp = 57'($urandom);
      chk("bp_res_fq_stable", 64'(o_rf), 64'(x));
      chk("bp_start_ready",   64'(o_sr), 64'd0);
      chk("bp_res_valid_hold",64'(o_rv), 64'd1);
      @(negedge clk);
    end
    rr = 1'b1; sv = 1'b1; op_fdiv = 1'b1; op_db = 1'b0; fq_dp = 57'h5A5;
    @(negedge clk);
    sv = 1'b0; rr = 1'b0;
    chk("b2b_pass_idx", 64'(o_pi), 64'd0);
    chk("b2b_busy",     64'(o_bz), 64'd1);
    chk("b2b_oe",       64'(o_oe), 64'b110);
    chk("b2b_res_valid",64'(o_rv), 64'd0);
    chk("b2b_dp_fdiv",  64'(o_df), 64'd1);
    wait_consume(40);

    // Reset pulsed while in NR_B aborts the operation.
    @(negedge clk);
    sel = 1'b0; sv = 1'b1; op_fdiv = 1'b1; op_db = 1'b0; fq_dp = 57'h777;
    repeat (5) begin
      @(negedge clk);
      sv = 1'b0;
    end
    chk("abort_in_nr_b", 64'(o_oe), 64'b101);
    rst_n = 1'b0;
    #1;
    chk("abort_oe",       64'(o_oe), 64'd0);
    chk("abort_pass_idx", 64'(o_pi), 64'd0);
    chk("abort_busy",     64'(o_bz), 64'd0);
    chk("abort_res_valid",64'(o_rv), 64'd0);
    chk("abort_res_fq",   64'(o_rf), 64'd0);
    chk("abort_dp",       64'({o_df, o_db}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (o_rv) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_vec(vecs[0]);

`ifdef MD_SEQ_PERF_EN
    begin
      int unsigned cons;
      int unsigned guard;
      cons = 0; guard = 0;
      @(negedge clk);
      sel = 1'b1; sv = 1'b1; rr = 1'b1; op_fdiv = 1'b1; op_db = 1'b0;
      while (cons < 65538 && guard < 1000000) begin
        @(negedge clk);
        guard++;
        if (o_rv) begin
          cons++;
          if (cons == 65537) op_fdiv = 1'b0;
          if (cons == 65538) sv = 1'b0;
        end
      end
      chk("perf_timeout", 64'(cons), 64'd65538);
      @(negedge clk);
      rr = 1'b0;
      chk("perf_div_cnt", 64'(pc1), 64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 The block SHALL have parameter MUL_LAT, default 2, meaning cycles each datapath multiply pass is held (legal 1..4).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  request accepted when both high
- op_fdiv  in  1  1 = divide, 0 = multiply; sampled on accept
- op_db  in  1  1 = double, 0 = single; sampled on accept
- fq_dp  in  57  significand result from the multiply/divide datapath
- dp_fdiv  out  1  registered op_fdiv to datapath
- dp_db  out  1  registered op_db to datapath
- oe1  out  2  datapath operand-select enable
- oe2  out  1  datapath operand-select enable
- pass_idx  out  4  current pass number, 0-based
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  result consumed when both high
- res_fq  out  57  captured result

Function
REQ-004 States SHALL be IDLE, MUL, LOOKUP, NR_A, NR_B, Q_A, Q_B, Q_SEL and RESULT, each with a fixed {oe1,oe2} encoding: IDLE 00/0, MUL 00/0, LOOKUP 11/0, NR_A 11/0, NR_B 10/1, Q_A 01/1, Q_B 01/0, Q_SEL 00/0, RESULT holds the last value.
REQ-005 start_ready SHALL be 1 in IDLE, and equal to res_ready in RESULT; it SHALL be 0 elsewhere.
REQ-006 On accept, op_fdiv and op_db SHALL be captured into dp_fdiv and dp_db, which hold until the next accept.
REQ-007 Each pass state SHALL last exactly MUL_LAT cycles, counted by a pass-cycle counter that reloads on every state entry.
REQ-008 Multiply: accept -> MUL (1 pass) -> RESULT.
REQ-009 Divide: accept -> LOOKUP -> N iterations of NR_A then NR_B -> Q_A -> Q_B -> Q_SEL -> RESULT. N = 2 for single, 3 for double; an iteration counter loads N on accept.
REQ-010 Total passes SHALL be 1 for multiply, 8 for single divide and 10 for double divide.
REQ-011 pass_idx SHALL be 0 on the first pass and increment by 1 per pass; it is 0 in IDLE.
REQ-012 res_fq SHALL capture fq_dp on the last cycle of the final pass (MUL or Q_SEL).
REQ-013 res_valid SHALL assert on the following cycle, exactly passes*MUL_LAT+1 cycles after the accept cycle.
REQ-014 res_valid and res_fq SHALL hold stable until res_ready is high.
REQ-015 When a result is consumed with no accept in the same cycle, the next state SHALL be IDLE.
REQ-016 A simultaneous result consume and start accept in RESULT SHALL start the new operation with no idle cycle.
REQ-017 start_valid while busy and not in RESULT SHALL be ignored; no queuing.
REQ-018 res_fq SHALL NOT change except on capture.

Reset
REQ-019 Reset SHALL force IDLE and clear every output to 0: oe1, oe2, dp_fdiv, dp_db, pass_idx, busy, res_valid and res_fq. All counters SHALL also clear.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no result produced; the first accept after reset release behaves normally.

Configuration
REQ-021 With MD_SEQ_PERF_EN defined, the block SHALL add output perf_div_cnt (16 bits), which increments on each consumed divide result.
REQ-022 perf_div_cnt SHALL wrap from 0xFFFF to 0 and be cleared by reset.
REQ-023 Without MD_SEQ_PERF_EN, the port and the counter SHALL be absent and all other behaviour identical.

Structure
REQ-024 A shared package md_pkg SHALL hold the state enum, the {oe1,oe2} encodings per state, the pass counts (1, 8, 10) and the iteration counts (2, 3).
REQ-025 One sub-module, md_pass_timer, SHALL be used: a loadable down-counter that asserts pass_last on the final cycle of a pass.

Verification
REQ-026 Multiply, MUL_LAT=2, fq_dp=57'h1: res_valid rises on cycle 3 after accept, res_fq=57'h1, oe1/oe2 = 00/0 throughout.
REQ-027 Single divide, MUL_LAT=2: oe sequence 11/0, then (11/0, 10/1) twice, then 01/1, 01/0, 00/0, each held 2 cycles; pass_idx runs 0..7; res_valid rises on cycle 17.
REQ-028 Double divide, MUL_LAT=1: 10 passes, res_valid rises on cycle 11, dp_db=1 throughout.
REQ-029 res_ready held low for 5 cycles: res_fq is stable and start_ready=0; then res_ready=1 together with start_valid=1 makes the next pass_idx 0 on the following cycle.
REQ-030 rst_n pulsed low during NR_B: all outputs read 0 and res_valid never asserts for the aborted operation.
REQ-031 With MD_SEQ_PERF_EN, 65537 consumed divides followed by 1 multiply: perf_div_cnt = 1.
